// File: rtl/display_ctrl.sv
// Two-requester round-robin frame arbiter feeding a display engine; each granted frame is shown REPEAT passes.
// Optional macro DISPLAY_CTRL_HOLD_EN: keep refreshing the last frame while no request is pending.
module display_ctrl #(
    parameter int GS     = 8,
    parameter int REPEAT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_i,
    input  logic [GS*GS-1:0] frame0_i,
    output logic             ack0_o,
    input  logic             req1_i,
    input  logic [GS*GS-1:0] frame1_i,
    output logic             ack1_o,
    output logic [GS*GS-1:0] matrix_o,
    output logic             e_disp_o,
    input  logic             d_disp_i,
    output logic             busy_o,
    output logic             owner_o
);

    localparam int CW = $clog2(REPEAT) + 1;
    localparam logic [CW-1:0] LAST_PASS = CW'(REPEAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      pass_cnt, pass_cnt_nx;
    logic [GS*GS-1:0]   matrix_nx;
    logic               e_disp_nx;
    logic               ack0_nx;
    logic               ack1_nx;
    logic               busy_nx;
    logic               owner_nx;
    logic               grant0;
    logic               grant1;
`ifdef DISPLAY_CTRL_HOLD_EN
    logic               frame_valid, frame_valid_nx;
`endif

    // Priority goes to the requester that was not granted last.
    assign grant0 = req0_i && (!req1_i || owner_o);
    assign grant1 = req1_i && (!req0_i || !owner_o);

    always_comb begin
        state_nx       = state;
        pass_cnt_nx    = pass_cnt;
        matrix_nx      = matrix_o;
        e_disp_nx      = 1'b0;
        ack0_nx        = 1'b0;
        ack1_nx        = 1'b0;
        owner_nx       = owner_o;
`ifdef DISPLAY_CTRL_HOLD_EN
        frame_valid_nx = frame_valid;
`endif
        case (state)
            IDLE: begin
                if (grant0) begin
                    matrix_nx      = frame0_i;
                    ack0_nx        = 1'b1;
                    owner_nx       = 1'b0;
                    pass_cnt_nx    = '0;
                    state_nx       = START;
`ifdef DISPLAY_CTRL_HOLD_EN
                    frame_valid_nx = 1'b1;
`endif
                end else if (grant1) begin
                    matrix_nx      = frame1_i;
                    ack1_nx        = 1'b1;
                    owner_nx       = 1'b1;
                    pass_cnt_nx    = '0;
                    state_nx       = START;
`ifdef DISPLAY_CTRL_HOLD_EN
                    frame_valid_nx = 1'b1;
`endif
                end
`ifdef DISPLAY_CTRL_HOLD_EN
                else if (frame_valid) begin
                    pass_cnt_nx = '0;
                    state_nx    = START;
                end
`endif
            end
            START: begin
                e_disp_nx = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: begin
                if (d_disp_i) begin
                    if (pass_cnt == LAST_PASS) begin
                        state_nx = IDLE;
                    end else begin
                        pass_cnt_nx = pass_cnt + 1'b1;
                        state_nx    = START;
                    end
                end else begin
                    e_disp_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            pass_cnt    <= '0;
            matrix_o    <= '0;
            e_disp_o    <= 1'b0;
            ack0_o      <= 1'b0;
            ack1_o      <= 1'b0;
            busy_o      <= 1'b0;
            owner_o     <= 1'b1;
`ifdef DISPLAY_CTRL_HOLD_EN
            frame_valid <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            pass_cnt    <= pass_cnt_nx;
            matrix_o    <= matrix_nx;
            e_disp_o    <= e_disp_nx;
            ack0_o      <= ack0_nx;
            ack1_o      <= ack1_nx;
            busy_o      <= busy_nx;
            owner_o     <= owner_nx;
`ifdef DISPLAY_CTRL_HOLD_EN
            frame_valid <= frame_valid_nx;
`endif
        end
    end

endmodule

// File: tb/tb_display_ctrl.sv
// Scoreboard bench for display_ctrl: stimulus queues expected acks and display passes, a monitor checks them.
module tb_display_ctrl;

    localparam int GS = 8;
    localparam int N  = GS * GS;
    localparam int DLY = 2;

    localparam logic [N-1:0] F0 = 64'h8040201008040201;
    localparam logic [N-1:0] F1 = 64'hDEADBEEF01234567;
    localparam logic [N-1:0] F2 = 64'h0F0F0F0FF0F0F0F0;
    localparam logic [N-1:0] F3 = 64'h123456789ABCDEF0;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1, ack0_o, ack1_o, e_disp_o, d_disp, busy_o, owner_o;
    logic [N-1:0] frame0, frame1, matrix_o;

    logic         req0_b, req1_b, ack0_b, ack1_b, e_disp_b, d_disp_b, busy_b, owner_b;
    logic [N-1:0] frame0_b, frame1_b, matrix_b;
    logic         force_b;

    typedef struct {
        int           kind;
        logic [N-1:0] data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   hi_cnt;

    always #5 clk = ~clk;

    display_ctrl #(.GS(GS), .REPEAT(4)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0), .frame0_i(frame0), .ack0_o(ack0_o),
        .req1_i(req1), .frame1_i(frame1), .ack1_o(ack1_o),
        .matrix_o(matrix_o), .e_disp_o(e_disp_o), .d_disp_i(d_disp),
        .busy_o(busy_o), .owner_o(owner_o)
    );

    display_ctrl #(.GS(GS), .REPEAT(1)) u_dut_r1 (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0_b), .frame0_i(frame0_b), .ack0_o(ack0_b),
        .req1_i(req1_b), .frame1_i(frame1_b), .ack1_o(ack1_b),
        .matrix_o(matrix_b), .e_disp_o(e_disp_b), .d_disp_i(d_disp_b),
        .busy_o(busy_b), .owner_o(owner_b)
    );

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [N-1:0] d, input int n);
        repeat (n) q.push_back('{kind, d});
    endtask

    // One clock step: requesters drop on ack, engine answers each pass after DLY+1 cycles.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ack0_o) req0 = 1'b0;
        if (ack1_o) req1 = 1'b0;
        if (ack0_b) req0_b = 1'b0;
        d_disp = 1'b0;
        if (e_disp_o) begin
            if (hi_cnt == DLY) begin
                d_disp = 1'b1;
                hi_cnt = 0;
            end else begin
                hi_cnt++;
            end
        end
        d_disp_b = e_disp_b ? 1'b1 : force_b;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d events pending after %0d cycles, required 0", name, q.size(), n);
            q.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; req0_b = 1'b0;
        d_disp = 1'b0; d_disp_b = 1'b0; force_b = 1'b0; hi_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic mon_event(input int kind);
        exp_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got event kind %0d matrix %h, required none", kind, matrix_o);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || matrix_o !== e.data ||
                (kind < 2 && owner_o !== (kind == 1))) begin
                bad++;
                $display("FAIL sb_event: got kind %0d matrix %h owner %b, required kind %0d matrix %h",
                         kind, matrix_o, owner_o, e.kind, e.data);
            end
        end
    endtask

    // Monitor: kind 0 = ack0, 1 = ack1, 2 = rising edge of e_disp_o.
    initial begin
        logic prev_e;
        prev_e = 1'b0;
        forever begin
            @(negedge clk);
            if (ack0_o) mon_event(0);
            if (ack1_o) mon_event(1);
            if (e_disp_o && !prev_e) mon_event(2);
            prev_e = e_disp_o;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, cnt, rises, acks;
        logic held, prev, seen_busy;

        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; frame0 = '0; frame1 = '0; d_disp = 1'b0;
        req0_b = 1'b0; req1_b = 1'b0; frame0_b = '0; frame1_b = '0; d_disp_b = 1'b0;
        force_b = 1'b0; hi_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_matrix", matrix_o, '0);
        check("rst_e_disp", e_disp_o, 0);
        check("rst_ack0", ack0_o, 0);
        check("rst_ack1", ack1_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_owner", owner_o, 1);
        check("rst_owner_r1", owner_b, 1);
        @(negedge clk);
        rst = 1'b0;

        // Single frame, four passes.
        push(0, F0, 1);
        push(2, F0, 4);
        req0 = 1'b1; frame0 = F0;
        tick();
        check("a_ack_latency", ack0_o, 1);
        check("a_busy", busy_o, 1);
        tick();
        check("a_ack_pulse", ack0_o, 0);
        check("a_edisp_latency", e_disp_o, 1);
        drain("a_passes", 200);
`ifdef DISPLAY_CTRL_HOLD_EN
        push(2, F0, 3);
        drain("a_hold_refresh", 200);
        check("a_hold_matrix", matrix_o, F0);
`else
        n = 0;
        while (busy_o && n < 50) begin
            tick();
            n++;
        end
        check("a_back_idle", busy_o, 0);
        cnt = 0;
        repeat (12) begin
            tick();
            if (e_disp_o) cnt++;
        end
        check("a_no_refresh", cnt, 0);
        check("a_matrix_kept", matrix_o, F0);
`endif
        do_reset();

        // Simultaneous requests: round-robin order 0, 1, then 0 again.
        push(0, F2, 1); push(2, F2, 4);
        push(1, F3, 1); push(2, F3, 4);
        req0 = 1'b1; frame0 = F2; req1 = 1'b1; frame1 = F3;
        drain("b_rr_first", 400);
        push(0, F0, 1); push(2, F0, 4);
        push(1, F1, 1); push(2, F1, 4);
        req0 = 1'b1; frame0 = F0; req1 = 1'b1; frame1 = F1;
        drain("b_rr_second", 400);
        do_reset();

        // Request arriving mid-display waits for IDLE; matrix holds meanwhile.
        push(0, F1, 1); push(2, F1, 1);
        req0 = 1'b1; frame0 = F1;
        drain("c_first_pass", 50);
        push(2, F1, 3);
        push(1, F2, 1); push(2, F2, 4);
        req1 = 1'b1; frame1 = F2;
        n = 0;
        held = 1'b1;
        while (!ack1_o && n < 200) begin
            if (matrix_o !== F1) held = 1'b0;
            tick();
            n++;
        end
        check("c_matrix_held", held, 1);
        check("c_ack1_seen", ack1_o, 1);
        drain("c_rest", 200);
        do_reset();

        // Reset during the third pass, then a fresh arbitration.
        push(0, F3, 1); push(2, F3, 3);
        req0 = 1'b1; frame0 = F3;
        drain("d_three_passes", 200);
        check("d_in_wait", e_disp_o, 1);
        rst = 1'b1;
        d_disp = 1'b0; hi_cnt = 0;
        #1;
        check("d_rst_matrix", matrix_o, '0);
        check("d_rst_e_disp", e_disp_o, 0);
        check("d_rst_busy", busy_o, 0);
        check("d_rst_owner", owner_o, 1);
        @(negedge clk);
        rst = 1'b0;
        push(0, F0, 1); push(2, F0, 4);
        push(1, F1, 1); push(2, F1, 4);
        req0 = 1'b1; frame0 = F0; req1 = 1'b1; frame1 = F1;
        tick();
        check("d_restart_ack0", ack0_o, 1);
        drain("d_restart", 400);
        do_reset();

        // REPEAT=1 instance: d_disp in IDLE is ignored, one pass per frame.
        force_b = 1'b1;
        repeat (3) tick();
        check("e_idle_e_disp", e_disp_b, 0);
        check("e_idle_busy", busy_b, 0);
        force_b = 1'b0;
        for (int k = 0; k < 2; k++) begin
            frame0_b = (k == 0) ? F2 : F3;
            req0_b = 1'b1;
            rises = 0; acks = 0; prev = 1'b0; seen_busy = 1'b0;
            for (int c = 0; c < 30; c++) begin
                tick();
                if (ack0_b) acks++;
                if (e_disp_b && !prev) rises++;
                prev = e_disp_b;
                if (busy_b) seen_busy = 1'b1;
                else if (seen_busy) break;
            end
            check("e_one_pass", rises, 1);
            check("e_one_ack", acks, 1);
            check("e_matrix", matrix_b, (k == 0) ? F2 : F3);
        end
        do_reset();

        check("sb_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_ctrl.md
DISPLAY_CTRL -- requirements
Module: display_ctrl

Interface
REQ-001 The module SHALL have one clock and one reset; the reset is asynchronous and active-high: clk_i, rst_i.
REQ-002 The module SHALL have parameter GS, default 8, giving the matrix edge length; each frame is GS*GS bits.
REQ-003 The module SHALL have parameter REPEAT, default 4, giving the number of complete display passes per granted frame; legal values are 1 and above.
REQ-004 clk_i  in  1  system clock; all state changes occur on the rising edge.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 req0_i  in  1  requester 0 frame request (level), held until ack0_o.
REQ-007 frame0_i  in  GS*GS  requester 0 frame data, valid while req0_i is high.
REQ-008 ack0_o  out  1  one-cycle grant/accept pulse to requester 0.
REQ-009 req1_i  in  1  requester 1 frame request (level), held until ack1_o.
REQ-010 frame1_i  in  GS*GS  requester 1 frame data, valid while req1_i is high.
REQ-011 ack1_o  out  1  one-cycle grant/accept pulse to requester 1.
REQ-012 matrix_o  out  GS*GS  latched frame driven to the display matrix input.
REQ-013 e_disp_o  out  1  display enable (level) to the display engine.
REQ-014 d_disp_i  in  1  display pass-done from the display engine.
REQ-015 busy_o  out  1  high whenever the state is not IDLE.
REQ-016 owner_o  out  1  index of the most recently granted requester.

Function
REQ-017 The FSM SHALL have states IDLE, START and WAIT, with all outputs registered.
REQ-018 In IDLE with any request pending, the module SHALL grant by round-robin, giving priority to the requester not granted last; after reset, requester 0 has priority.
REQ-019 On a grant, on the next edge the module SHALL latch the granted frame into matrix_o, pulse the matching ack for exactly 1 cycle, update owner_o, clear pass_cnt and enter START.
REQ-020 In START, the module SHALL drive e_disp_o high and enter WAIT on the next edge.
REQ-021 In WAIT, the module SHALL hold e_disp_o high until d_disp_i is sampled high, then drive e_disp_o low on that edge.
REQ-022 When d_disp_i is sampled high in WAIT and pass_cnt equals REPEAT-1, the module SHALL go to IDLE; otherwise it SHALL increment pass_cnt and go to START.
REQ-023 pass_cnt SHALL be clog2(REPEAT)+1 bits wide and SHALL never wrap past REPEAT-1.
REQ-024 matrix_o SHALL remain constant from a grant until the next grant.
REQ-025 A request arriving in START or WAIT SHALL stay pending without an ack and SHALL be arbitrated on entry to IDLE.
REQ-026 When both requests are high in the same cycle, only the priority holder SHALL be acked; the other SHALL be served at the next IDLE.
REQ-027 d_disp_i SHALL be ignored in IDLE and START.
REQ-028 Minimum latency from a req in IDLE to ack SHALL be 1 cycle, and to e_disp_o rising SHALL be 2 cycles.

Reset
REQ-029 While rst_i is high, regardless of state or mid-pass, the module SHALL force: state IDLE; matrix_o=0; e_disp_o=0; ack0_o=0; ack1_o=0; busy_o=0; owner_o=1 (so requester 0 has priority); pass_cnt=0; frame-valid flag=0.
REQ-030 After reset release, the module SHALL accept a grant on the first rising edge.

Configuration
REQ-031 With macro DISPLAY_CTRL_HOLD_EN defined, in IDLE with no request and frame-valid=1, the module SHALL re-enter START with pass_cnt=0 and no ack, refreshing the held frame indefinitely; requests always take precedence.
REQ-032 Without DISPLAY_CTRL_HOLD_EN, the module SHALL remain in IDLE with e_disp_o=0 until a request arrives.

Verification
REQ-033 Test: reset, then req0 with frame0=64'h8040201008040201 -> ack0 1 cycle later, matrix_o equal to that value, and exactly 4 e_disp_o high/low passes before IDLE.
REQ-034 Test: req0 and req1 raised in the same cycle after reset -> ack0 first; ack1 after 4 passes; a further simultaneous request -> ack0 again.
REQ-035 Test: req1 raised during WAIT -> no ack until IDLE; matrix_o unchanged until ack1.
REQ-036 Test: rst_i asserted in WAIT with pass_cnt=2 -> all outputs 0 immediately and owner_o=1; restart behaves as a fresh grant.
REQ-037 Test: REPEAT=1 with d_disp_i pulsed -> one pass per frame; d_disp_i in IDLE has no effect.
REQ-038 Test: with DISPLAY_CTRL_HOLD_EN, no requests after the first frame -> e_disp_o keeps cycling with the same matrix_o; without the macro -> e_disp_o stays 0.
